// File: rtl/bundle_packer.sv
// Packs ALU-slot and mem/ctrl-slot halfwords into 32-bit bundles.
// Optional stats counters: define BUNDLE_PACKER_STATS_EN.
module bundle_packer #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  output logic        b_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_bundle,
  input  logic        out_ready,
  output logic        illegal_op
`ifdef BUNDLE_PACKER_STATS_EN
  ,
  output logic [15:0] bundle_cnt,
  output logic [15:0] pad_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic [15:0]   a_mem [DEPTH];
  logic [15:0]   b_mem [DEPTH];
  logic [PW-1:0] a_wp, a_rp, b_wp, b_rp;
  logic [CW-1:0] a_cnt, b_cnt;
  logic [3:0]    wcnt;

  logic a_legal, b_legal;
  logic push_a, push_b, pop_a, pop_b;
  logic a_ne, b_ne, one, can_load, emit;
  logic [15:0] a_word, b_word, a_head, b_head;

  always_comb begin
    a_legal = 1'b0;
    case (a_data[4:0])
      5'b01000: a_legal = (a_data[7:5] == 3'b100) ||
                          (a_data[7:5] == 3'b011) ||
                          (a_data[7:5] == 3'b010);
      5'b00101,
      5'b00000: a_legal = 1'b1;
      default:  a_legal = 1'b0;
    endcase
  end

  always_comb begin
    b_legal = 1'b0;
    case (b_data[4:0])
      5'b01010, 5'b01011,
      5'b11110, 5'b11011,
      5'b00000: b_legal = 1'b1;
      default:  b_legal = 1'b0;
    endcase
  end

  assign a_word   = a_legal ? a_data : 16'h0000;
  assign b_word   = b_legal ? b_data : 16'h0000;
  assign a_ready  = (a_cnt != FULL);
  assign b_ready  = (b_cnt != FULL);
  assign push_a   = a_valid && a_ready;
  assign push_b   = b_valid && b_ready;
  assign a_ne     = (a_cnt != '0);
  assign b_ne     = (b_cnt != '0);
  assign one      = a_ne ^ b_ne;
  assign can_load = !out_valid || out_ready;
  // Pairs go out immediately; a lone half waits for timeout or flush
  assign emit     = can_load &&
                    ((a_ne && b_ne) || (one && ((wcnt == MW) || flush)));
  assign pop_a    = emit && a_ne;
  assign pop_b    = emit && b_ne;
  assign a_head   = a_ne ? a_mem[a_rp] : 16'h0000;
  assign b_head   = b_ne ? b_mem[b_rp] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem[i] <= 16'h0000;
        b_mem[i] <= 16'h0000;
      end
      a_wp  <= '0;
      a_rp  <= '0;
      b_wp  <= '0;
      b_rp  <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (push_a) begin
        a_mem[a_wp] <= a_word;
        a_wp        <= a_wp + 1'b1;
      end
      if (push_b) begin
        b_mem[b_wp] <= b_word;
        b_wp        <= b_wp + 1'b1;
      end
      if (pop_a) a_rp <= a_rp + 1'b1;
      if (pop_b) b_rp <= b_rp + 1'b1;
      a_cnt <= a_cnt + CW'(push_a) - CW'(pop_a);
      b_cnt <= b_cnt + CW'(push_b) - CW'(pop_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 4'd0;
    end else if (emit || !one) begin
      wcnt <= 4'd0;
    end else if (wcnt != MW) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_bundle <= 32'h0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_bundle <= {b_head, a_head};
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else if ((push_a && !a_legal) || (push_b && !b_legal)) begin
      illegal_op <= 1'b1;
    end
  end

`ifdef BUNDLE_PACKER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_cnt <= 16'h0;
      pad_cnt    <= 16'h0;
    end else begin
      if (out_valid && out_ready) bundle_cnt <= bundle_cnt + 16'd1;
      if (emit && one)            pad_cnt    <= pad_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bundle_packer.sv
// Scoreboard bench for bundle_packer: directed vectors,
// expected bundles queued at stimulus, checked by a monitor.
module tb_bundle_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, flush, out_ready;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, illegal_op;
  logic [31:0] out_bundle;
`ifdef BUNDLE_PACKER_STATS_EN
  logic [15:0] bundle_cnt, pad_cnt;
`endif

  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bundle_packer #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_bundle (out_bundle),
    .out_ready  (out_ready),
    .illegal_op (illegal_op)
`ifdef BUNDLE_PACKER_STATS_EN
    ,
    .bundle_cnt (bundle_cnt),
    .pad_cnt    (pad_cnt)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
    int n;
    a_valid = 1'b1;
    a_data  = a;
    b_valid = 1'b1;
    b_data  = b;
    n = 0;
    while (!(a_ready && b_ready) && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n == 20) begin
      bad++;
      $display("FAIL push_timeout: got ready=%b%b want 11", a_ready, b_ready);
    end
    exp_q.push_back(exp);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
  endtask

  // Monitor: pops on each handshake, also checks hold under backpressure
  initial begin
    logic        held;
    logic [31:0] held_v;
    held = 1'b0;
    held_v = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", {31'h0, out_valid}, 32'h1);
          check("hold_bundle", out_bundle, held_v);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected: got %h want none", out_bundle);
          end else begin
            check("bundle", out_bundle, exp_q.pop_front());
          end
        end
        held   = out_valid && !out_ready;
        held_v = out_bundle;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data = 16'h0;
    b_data = 16'h0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_bundle", out_bundle, 32'h0);
    check("rst_illegal", {31'h0, illegal_op}, 32'h0);
    check("rst_ready", {30'h0, a_ready, b_ready}, 32'h3);

    // pair emitted one edge after acceptance, single pulse
    push_pair(16'h0088, 16'h000A, 32'h000A0088);
    step();
    check("pair_valid", {31'h0, out_valid}, 32'h1);
    check("pair_bundle", out_bundle, 32'h000A0088);
    step();
    check("pair_pulse", {31'h0, out_valid}, 32'h0);

    // lone A halfword times out after MAX_WAIT
    a_valid = 1'b1;
    a_data  = 16'h0025;
    exp_q.push_back(32'h00000025);
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("lone_wait", {31'h0, out_valid}, 32'h0);
      step();
    end
    check("lone_valid", {31'h0, out_valid}, 32'h1);
    check("lone_bundle", out_bundle, 32'h00000025);
    step();
    drain();

    // lone B halfword, flushed the next cycle
    b_valid = 1'b1;
    b_data  = 16'h001E;
    exp_q.push_back(32'h001E0000);
    step();
    b_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", {31'h0, out_valid}, 32'h1);
    check("flush_bundle", out_bundle, 32'h001E0000);
    check("flush_wcnt", {28'h0, dut.wcnt}, 32'h0);
    drain();

    // flush with nothing queued does nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_empty", {31'h0, out_valid}, 32'h0);

    // backpressure: 5 pairs fill output reg plus both FIFOs
    out_ready = 1'b0;
    push_pair(16'h1025, 16'h100A, 32'h100A1025);
    push_pair(16'h2025, 16'h200B, 32'h200B2025);
    push_pair(16'h3025, 16'h301E, 32'h301E3025);
    push_pair(16'h4025, 16'h401B, 32'h401B4025);
    push_pair(16'h5025, 16'h500A, 32'h500A5025);
    check("full_ready", {30'h0, a_ready, b_ready}, 32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    check("full_bundle", out_bundle, 32'h100A1025);
    repeat (3) step();
    out_ready = 1'b1;
    drain();

    // illegal function code is stored as NOP and sets the flag
    push_pair(16'h0068, 16'h000A, 32'h000A0068);
    push_pair(16'h00E8, 16'h000B, 32'h000B0000);
    drain();
    check("illegal_set", {31'h0, illegal_op}, 32'h1);
    repeat (3) step();
    check("illegal_sticky", {31'h0, illegal_op}, 32'h1);

    // async reset discards queued and held bundles
    out_ready = 1'b0;
    push_pair(16'h1025, 16'h100A, 32'h100A1025);
    push_pair(16'h2025, 16'h200B, 32'h200B2025);
    push_pair(16'h3025, 16'h301E, 32'h301E3025);
    check("prerst_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'h0);
    check("async_bundle", out_bundle, 32'h0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_ready", {30'h0, a_ready, b_ready}, 32'h3);
    check("post_illegal", {31'h0, illegal_op}, 32'h0);
    repeat (10) step();
    check("post_valid", {31'h0, out_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
